// File: rtl/lcd1602_disp_ctrl.sv
// LCD1602 sequencer: HD44780 power-up init, then 2x16 buffer redraws on request.
// Define LCD_BUSY_POLL_EN to replace the fixed execution waits with busy-flag polling.
module lcd1602_disp_ctrl #(
  parameter logic [15:0] ACCESS_CYCLES = 16'd504,
  parameter logic [19:0] PWRUP_WAIT    = 20'd750000,
  parameter logic [19:0] CMD_WAIT      = 20'd2000,
  parameter logic [19:0] CLR_WAIT      = 20'd80000,
  parameter logic [15:0] POLL_LIMIT    = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refresh,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_wdata,
  input  logic [7:0] lcd_rdata,
  output logic       lcd_write,
  output logic       lcd_read,
  output logic [7:0] lcd_wdata,
  output logic       lcd_reg_sel,
  output logic       busy,
  output logic       init_done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_PWRUP, S_ISSUE, S_ACCESS, S_EXEC, S_NEXT, S_IDLE, S_POLL
  } state_t;

  state_t      state, state_next;
  logic [19:0] cnt, cnt_next;
  logic [5:0]  idx, idx_next;
  logic        frame, frame_next;
  logic        pending, pend_clr, init_set, err_set;
  logic [7:0]  buf_mem [32];
  logic [7:0]  op_byte;
  logic        op_rs;
  logic [4:0]  bi;
  logic        access_end;
  logic        unused;

  assign access_end = (cnt == ({4'd0, ACCESS_CYCLES} - 20'd1));

`ifdef LCD_BUSY_POLL_EN
  logic [15:0] poll_cnt;
  assign unused = ^{CMD_WAIT, CLR_WAIT, lcd_rdata[6:0]};
`else
  logic [19:0] exec_wait;
  // Clear needs the long wait; a data byte of 0x01 is an ordinary write.
  assign exec_wait = (lcd_wdata == 8'h01 && !lcd_reg_sel) ? CLR_WAIT : CMD_WAIT;
  assign unused    = ^{lcd_rdata, POLL_LIMIT};
  assign lcd_read  = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state, counter and operation-select logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 20'd1;
    idx_next   = idx;
    frame_next = frame;
    pend_clr   = 1'b0;
    init_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_PWRUP: begin
        if (cnt == PWRUP_WAIT) begin
          state_next = S_ISSUE;
          cnt_next   = 20'd0;
          idx_next   = 6'd0;
          frame_next = 1'b0;
        end else begin
          state_next = S_PWRUP;
        end
      end
      S_ISSUE: begin
        state_next = S_ACCESS;
        cnt_next   = 20'd0;
      end
      S_ACCESS: begin
        if (access_end) begin
          state_next = S_EXEC;
          cnt_next   = 20'd0;
        end else begin
          state_next = S_ACCESS;
        end
      end
`ifdef LCD_BUSY_POLL_EN
      S_EXEC: begin
        state_next = S_POLL;
        cnt_next   = 20'd0;
      end
      S_POLL: begin
        if (access_end) begin
          cnt_next = 20'd0;
          if (!lcd_rdata[7]) begin
            state_next = S_NEXT;
          end else if (poll_cnt >= POLL_LIMIT) begin
            state_next = S_NEXT;
            err_set    = 1'b1;
          end else begin
            state_next = S_EXEC;
          end
        end else begin
          state_next = S_POLL;
        end
      end
`else
      // EXEC lasts wait-1 cycles; NEXT supplies the final cycle of the wait.
      S_EXEC: begin
        if (cnt + 20'd2 >= exec_wait) begin
          state_next = S_NEXT;
        end else begin
          state_next = S_EXEC;
        end
      end
`endif
      S_NEXT: begin
        if (idx == (frame ? 6'd33 : 6'd3)) begin
          state_next = S_IDLE;
          init_set   = !frame;
        end else begin
          state_next = S_ISSUE;
          idx_next   = idx + 6'd1;
        end
      end
      S_IDLE: begin
        if (pending) begin
          state_next = S_NEXT;
          idx_next   = 6'h3F;
          frame_next = 1'b1;
          pend_clr   = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_PWRUP;
    endcase

    bi = (idx_next < 6'd17) ? (idx_next[4:0] - 5'd1) : (idx_next[4:0] - 5'd2);
    if (!frame_next) begin
      op_rs = 1'b0;
      case (idx_next[1:0])
        2'd0:    op_byte = 8'h38;
        2'd1:    op_byte = 8'h0C;
        2'd2:    op_byte = 8'h06;
        default: op_byte = 8'h01;
      endcase
    end else if (idx_next == 6'd0) begin
      op_rs   = 1'b0;
      op_byte = 8'h80;
    end else if (idx_next == 6'd17) begin
      op_rs   = 1'b0;
      op_byte = 8'hC0;
    end else begin
      op_rs   = 1'b1;
      op_byte = buf_mem[bi];
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PWRUP;
      cnt         <= 20'd0;
      idx         <= 6'd0;
      frame       <= 1'b0;
      pending     <= 1'b0;
      lcd_write   <= 1'b0;
      lcd_wdata   <= 8'h00;
      lcd_reg_sel <= 1'b0;
      busy        <= 1'b1;
      init_done   <= 1'b0;
      for (int i = 0; i < 32; i++) buf_mem[i] <= 8'h20;
`ifdef LCD_BUSY_POLL_EN
      lcd_read    <= 1'b0;
      err         <= 1'b0;
      poll_cnt    <= 16'd0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      frame     <= frame_next;
      busy      <= (state_next != S_IDLE);
      lcd_write <= (state_next == S_ISSUE);
      if (refresh) pending <= 1'b1;
      else if (pend_clr) pending <= 1'b0;
      else pending <= pending;
      if (init_set) init_done <= 1'b1;
      if (buf_we) buf_mem[buf_addr] <= buf_wdata;
      if (state_next == S_ISSUE) begin
        lcd_wdata   <= op_byte;
        lcd_reg_sel <= op_rs;
      end
`ifdef LCD_BUSY_POLL_EN
      lcd_read <= (state_next == S_EXEC);
      if (state_next == S_EXEC) lcd_reg_sel <= 1'b0;
      if (err_set) err <= 1'b1;
      if (state == S_ACCESS) poll_cnt <= 16'd0;
      else if (state == S_EXEC) poll_cnt <= poll_cnt + 16'd1;
`endif
    end
  end

endmodule
